// File: rtl/cfg.sv
// rtl/cfg.sv - shared address and data widths
package cfg_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/ram_arb_if.sv
// rtl/ram_arb_if.sv - requester and RAM signal bundle for ram_arb
interface ram_arb_if;
  import cfg_pkg::*;

  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_req_addr;
  logic                  ifu_rsp_valid;
  logic [DATA_WIDTH-1:0] ifu_rsp_data;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic                  lsu_req_wr_en;
  logic [1:0]            lsu_req_size;
  logic [ADDR_WIDTH-1:0] lsu_req_addr;
  logic [DATA_WIDTH-1:0] lsu_req_wr_data;
  logic                  lsu_rsp_valid;
  logic [DATA_WIDTH-1:0] lsu_rsp_data;
  logic                  lsu_rsp_err;

  logic                  ram_en;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_valid, lsu_req_wr_en, lsu_req_size, lsu_req_addr, lsu_req_wr_data,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
    output ram_en, ram_wr_en, ram_addr, ram_wr_data,
    input  ram_rd_data
  );

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_valid, lsu_req_wr_en, lsu_req_size, lsu_req_addr, lsu_req_wr_data,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
    input  ram_en, ram_wr_en, ram_addr, ram_wr_data,
    output ram_rd_data
  );
endinterface

// File: rtl/ram_arb.sv
// rtl/ram_arb.sv - round-robin IFU/LSU arbiter with sub-word store read-modify-write
module ram_arb
  import cfg_pkg::*;
(
  input logic      i_sys_clk,
  input logic      i_sys_rst_n,
  ram_arb_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MERGE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]            r_state;
  logic                  r_last_gnt;
  logic                  r_owner;
  logic                  r_err;
  logic                  r_rd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic                  gnt_ifu, gnt_lsu, accept;
  logic                  is_byte, is_half, is_word;
  logic                  misal, sub_st, word_st;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] merged;

  // Arbitration and classification of the request that would be accepted now
  always_comb begin
    gnt_lsu  = bus.lsu_req_valid && (!bus.ifu_req_valid || !r_last_gnt);
    gnt_ifu  = bus.ifu_req_valid && !gnt_lsu;
    accept   = i_sys_rst_n && (r_state == S_IDLE) && (gnt_ifu || gnt_lsu);
    req_addr = gnt_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
    is_byte  = (bus.lsu_req_size == 2'b00);
    is_half  = (bus.lsu_req_size == 2'b01);
    is_word  = bus.lsu_req_size[1];
    misal    = gnt_lsu && ((is_half && bus.lsu_req_addr[0]) ||
                           (is_word && (bus.lsu_req_addr[1:0] != 2'b00)));
    sub_st   = gnt_lsu && bus.lsu_req_wr_en && !misal && (is_byte || is_half);
    word_st  = gnt_lsu && bus.lsu_req_wr_en && !misal && is_word;
  end

  // Replace the stored lanes of the freshly read word for the MERGE write
  always_comb begin
    merged = bus.ram_rd_data;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'd0:    merged[7:0]   = r_wr_data[7:0];
        2'd1:    merged[15:8]  = r_wr_data[7:0];
        2'd2:    merged[23:16] = r_wr_data[7:0];
        default: merged[31:24] = r_wr_data[7:0];
      endcase
    end else if (r_addr[1]) begin
      merged[31:16] = r_wr_data[15:0];
    end else begin
      merged[15:0]  = r_wr_data[15:0];
    end
  end

  // Output decode; everything is forced low while reset is asserted
  always_comb begin
    bus.ifu_req_ready = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_data  = '0;
    bus.lsu_rsp_valid = 1'b0;
    bus.lsu_rsp_data  = '0;
    bus.lsu_rsp_err   = 1'b0;
    bus.ram_en        = 1'b0;
    bus.ram_wr_en     = 1'b0;
    bus.ram_addr      = '0;
    bus.ram_wr_data   = '0;
    if (i_sys_rst_n) begin
      case (r_state)
        S_IDLE: begin
          bus.ifu_req_ready = gnt_ifu;
          bus.lsu_req_ready = gnt_lsu;
          if (accept && !misal) begin
            bus.ram_en      = 1'b1;
            bus.ram_wr_en   = word_st;
            bus.ram_addr    = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            bus.ram_wr_data = word_st ? bus.lsu_req_wr_data : '0;
          end
        end
        S_MERGE: begin
          bus.ram_en      = 1'b1;
          bus.ram_wr_en   = 1'b1;
          bus.ram_addr    = {r_addr[ADDR_WIDTH-1:2], 2'b00};
          bus.ram_wr_data = merged;
        end
        S_RESP: begin
          if (r_owner) begin
            bus.lsu_rsp_valid = 1'b1;
            bus.lsu_rsp_data  = r_rd ? bus.ram_rd_data : '0;
            bus.lsu_rsp_err   = r_err;
          end else begin
            bus.ifu_rsp_valid = 1'b1;
            bus.ifu_rsp_data  = r_rd ? bus.ram_rd_data : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // State sequencing and capture of the accepted request
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b0;
      r_owner    <= 1'b0;
      r_err      <= 1'b0;
      r_rd       <= 1'b0;
      r_addr     <= '0;
      r_size     <= '0;
      r_wr_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (accept) begin
            r_last_gnt <= gnt_lsu;
            r_owner    <= gnt_lsu;
            r_err      <= misal;
            r_rd       <= !misal && !(gnt_lsu && bus.lsu_req_wr_en);
            r_addr     <= req_addr;
            r_size     <= bus.lsu_req_size;
            r_wr_data  <= bus.lsu_req_wr_data;
            r_state    <= sub_st ? S_MERGE : S_RESP;
          end
        end
        S_MERGE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// tb/tb_ram_arb.sv - directed self-checking bench for ram_arb
module tb_ram_arb;

  logic clk;
  logic rst_n;
  ram_arb_if bus ();

  ram_arb dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  // Behavioural synchronous RAM with a backdoor preload port
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.ram_en) begin
      if (bus.ram_wr_en) mem[bus.ram_addr[7:2]] <= bus.ram_wr_data;
      else bus.ram_rd_data <= mem[bus.ram_addr[7:2]];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = addr[7:2]; pl_data = data;
    step();
    pl_en = 1'b0;
  endtask

  task automatic lsu_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data);
    bus.lsu_req_valid = 1'b1; bus.lsu_req_wr_en = wr; bus.lsu_req_size = size;
    bus.lsu_req_addr = addr; bus.lsu_req_wr_data = data;
  endtask

  // Expected pattern while both requesters hold valid: LSU first, then alternation
  logic exp_ifu_rdy [0:7] = '{0, 0, 1, 0, 0, 0, 1, 0};
  logic exp_lsu_rdy [0:7] = '{1, 0, 0, 0, 1, 0, 0, 0};
  logic exp_ifu_rsp [0:7] = '{0, 0, 0, 1, 0, 0, 0, 1};
  logic exp_lsu_rsp [0:7] = '{0, 1, 0, 0, 0, 1, 0, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    bus.ifu_req_valid = 1'b0; bus.ifu_req_addr = '0;
    bus.ram_rd_data = '0;
    lsu_req(1'b0, 2'b10, 32'h0, 32'h0);

    // Reset: everything low even with a request pending
    step();
    preload(32'h04, 32'h1111_1111);
    preload(32'h08, 32'h2222_2222);
    preload(32'h10, 32'hDEAD_BEEF);
    preload(32'h20, 32'h1122_3344);
    preload(32'h30, 32'hAABB_CCDD);
    #1;
    check("rst_lsu_ready", {31'd0, bus.lsu_req_ready}, 32'd0);
    check("rst_ifu_ready", {31'd0, bus.ifu_req_ready}, 32'd0);
    check("rst_ram_en",    {31'd0, bus.ram_en}, 32'd0);
    check("rst_ram_addr",  bus.ram_addr, 32'd0);
    check("rst_lsu_rsp",   {31'd0, bus.lsu_rsp_valid}, 32'd0);
    bus.lsu_req_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // LSU load from 0x10
    lsu_req(1'b0, 2'b10, 32'h10, 32'h0);
    #1;
    check("ld_ready",    {31'd0, bus.lsu_req_ready}, 32'd1);
    check("ld_ram_en",   {31'd0, bus.ram_en}, 32'd1);
    check("ld_ram_wr",   {31'd0, bus.ram_wr_en}, 32'd0);
    check("ld_ram_addr", bus.ram_addr, 32'h10);
    step(); bus.lsu_req_valid = 1'b0; #1;
    check("ld_rsp_valid", {31'd0, bus.lsu_rsp_valid}, 32'd1);
    check("ld_rsp_data",  bus.lsu_rsp_data, 32'hDEAD_BEEF);
    check("ld_rsp_err",   {31'd0, bus.lsu_rsp_err}, 32'd0);
    check("ld_ifu_rsp",   {31'd0, bus.ifu_rsp_valid}, 32'd0);

    // Reset again so the LSU wins the first conflict, then hold both valid
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h06;
    lsu_req(1'b0, 2'b10, 32'h08, 32'h0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_ifu_rdy%0d", k), {31'd0, bus.ifu_req_ready}, {31'd0, exp_ifu_rdy[k]});
      check($sformatf("rr_lsu_rdy%0d", k), {31'd0, bus.lsu_req_ready}, {31'd0, exp_lsu_rdy[k]});
      check($sformatf("rr_ifu_rsp%0d", k), {31'd0, bus.ifu_rsp_valid}, {31'd0, exp_ifu_rsp[k]});
      check($sformatf("rr_lsu_rsp%0d", k), {31'd0, bus.lsu_rsp_valid}, {31'd0, exp_lsu_rsp[k]});
      if (exp_ifu_rsp[k]) check($sformatf("rr_ifu_data%0d", k), bus.ifu_rsp_data, 32'h1111_1111);
      if (exp_lsu_rsp[k]) check($sformatf("rr_lsu_data%0d", k), bus.lsu_rsp_data, 32'h2222_2222);
      step();
    end
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;

    // Byte store 0xAB to 0x22 (upper store bits must be ignored)
    step();
    lsu_req(1'b1, 2'b00, 32'h22, 32'hFFFF_FFAB);
    #1;
    check("sb_ready",    {31'd0, bus.lsu_req_ready}, 32'd1);
    check("sb_rd_en",    {bus.ram_en, bus.ram_wr_en}, 32'd2);
    check("sb_rd_addr",  bus.ram_addr, 32'h20);
    step(); bus.lsu_req_valid = 1'b0; #1;
    check("sb_wr_en",    {bus.ram_en, bus.ram_wr_en}, 32'd3);
    check("sb_wr_addr",  bus.ram_addr, 32'h20);
    check("sb_wr_data",  bus.ram_wr_data, 32'h11AB_3344);
    check("sb_no_rsp",   {31'd0, bus.lsu_rsp_valid}, 32'd0);
    step(); #1;
    check("sb_rsp",      {bus.lsu_rsp_valid, bus.lsu_rsp_err}, 32'd2);
    check("sb_rsp_data", bus.lsu_rsp_data, 32'd0);
    check("sb_mem",      mem[8], 32'h11AB_3344);

    // Halfword store 0xCAFE to 0x12 over a zero word
    step();
    preload(32'h10, 32'h0);
    lsu_req(1'b1, 2'b01, 32'h12, 32'h1234_CAFE);
    #1;
    check("sh_rd_addr", bus.ram_addr, 32'h10);
    step(); bus.lsu_req_valid = 1'b0; #1;
    check("sh_wr_data", bus.ram_wr_data, 32'hCAFE_0000);
    step(); #1;
    check("sh_rsp",     {bus.lsu_rsp_valid, bus.lsu_rsp_err}, 32'd2);
    check("sh_mem",     mem[4], 32'hCAFE_0000);

    // Misaligned halfword store to 0x13
    step();
    lsu_req(1'b1, 2'b01, 32'h13, 32'h0000_BEEF);
    #1;
    check("mis_ready",  {31'd0, bus.lsu_req_ready}, 32'd1);
    check("mis_ram_en", {31'd0, bus.ram_en}, 32'd0);
    step(); bus.lsu_req_valid = 1'b0; #1;
    check("mis_rsp",    {bus.lsu_rsp_valid, bus.lsu_rsp_err}, 32'd3);
    check("mis_mem",    mem[4], 32'hCAFE_0000);

    // Word store then load back
    step();
    lsu_req(1'b1, 2'b10, 32'h40, 32'h1234_5678);
    #1;
    check("sw_wr_en",   {bus.ram_en, bus.ram_wr_en}, 32'd3);
    check("sw_addr",    bus.ram_addr, 32'h40);
    check("sw_data",    bus.ram_wr_data, 32'h1234_5678);
    step(); bus.lsu_req_valid = 1'b0; #1;
    check("sw_rsp",     {bus.lsu_rsp_valid, bus.lsu_rsp_err}, 32'd2);
    step();
    lsu_req(1'b0, 2'b10, 32'h40, 32'h0);
    step(); bus.lsu_req_valid = 1'b0; #1;
    check("sw_ld_rsp",  {31'd0, bus.lsu_rsp_valid}, 32'd1);
    check("sw_ld_data", bus.lsu_rsp_data, 32'h1234_5678);

    // Reset during the MERGE cycle of a byte store
    step();
    lsu_req(1'b1, 2'b00, 32'h31, 32'h55);
    #1;
    check("ab_ready",   {31'd0, bus.lsu_req_ready}, 32'd1);
    step(); bus.lsu_req_valid = 1'b0; rst_n = 1'b0; #1;
    check("ab_no_wr",   {bus.ram_en, bus.ram_wr_en}, 32'd0);
    step(); #1;
    check("ab_no_rsp",  {31'd0, bus.lsu_rsp_valid}, 32'd0);
    rst_n = 1'b1;
    step(); #1;
    check("ab_idle_rsp", {31'd0, bus.lsu_rsp_valid}, 32'd0);
    check("ab_mem",      mem[12], 32'hAABB_CCDD);
    step();
    lsu_req(1'b0, 2'b10, 32'h30, 32'h0);
    #1;
    check("ab_ld_ready", {31'd0, bus.lsu_req_ready}, 32'd1);
    step(); bus.lsu_req_valid = 1'b0; #1;
    check("ab_ld_data",  bus.lsu_rsp_data, 32'hAABB_CCDD);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
